// File: rtl/lsu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lsu_pkg : access formats, fault codes and FSM states of the LSU      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package lsu_pkg;

    localparam logic [2:0] FMT_B  = 3'b000;
    localparam logic [2:0] FMT_H  = 3'b001;
    localparam logic [2:0] FMT_W  = 3'b010;
    localparam logic [2:0] FMT_D  = 3'b011;
    localparam logic [2:0] FMT_BU = 3'b100;
    localparam logic [2:0] FMT_HU = 3'b101;
    localparam logic [2:0] FMT_WU = 3'b110;

    localparam logic [1:0] FAULT_NONE     = 2'b00;
    localparam logic [1:0] FAULT_MISALIGN = 2'b01;
    localparam logic [1:0] FAULT_FORMAT   = 2'b10;
    localparam logic [1:0] FAULT_TIMEOUT  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } lsu_state_t;

    // Access size in bytes; 0 marks a format the configured width cannot serve.
    function automatic logic [3:0] size_of_format(input logic [2:0] fmt, input logic wide);
        case (fmt)
            FMT_B, FMT_BU: size_of_format = 4'd1;
            FMT_H, FMT_HU: size_of_format = 4'd2;
            FMT_W:         size_of_format = 4'd4;
            FMT_D:         size_of_format = wide ? 4'd8 : 4'd0;
            FMT_WU:        size_of_format = wide ? 4'd4 : 4'd0;
            default:       size_of_format = 4'd0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/load_store_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | load_store_unit_if : core request/response and memory bus signals    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface load_store_unit_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;

    logic                  core_req_valid;
    logic                  core_req_ready;
    logic                  core_write;
    logic [2:0]            core_format;
    logic [ADDR_WIDTH-1:0] core_address;
    logic [DATA_WIDTH-1:0] core_write_data;
    logic                  core_resp_valid;
    logic [DATA_WIDTH-1:0] core_read_data;
    logic [1:0]            core_fault;

    logic                  bus_req_valid;
    logic                  bus_req_ready;
    logic [ADDR_WIDTH-1:0] bus_address;
    logic                  bus_write_enable;
    logic [BE_WIDTH-1:0]   bus_byte_enable;
    logic [DATA_WIDTH-1:0] bus_write_data;
    logic                  bus_resp_valid;
    logic [DATA_WIDTH-1:0] bus_read_data;

    // The unit: slave to the core, issuer on the bus.
    modport slave (
        input  core_req_valid, core_write, core_format, core_address, core_write_data,
        output core_req_ready, core_resp_valid, core_read_data, core_fault,
        output bus_req_valid, bus_address, bus_write_enable, bus_byte_enable, bus_write_data,
        input  bus_req_ready, bus_resp_valid, bus_read_data
    );

    // The surroundings: requesting core plus responding memory.
    modport master (
        output core_req_valid, core_write, core_format, core_address, core_write_data,
        input  core_req_ready, core_resp_valid, core_read_data, core_fault,
        input  bus_req_valid, bus_address, bus_write_enable, bus_byte_enable, bus_write_data,
        output bus_req_ready, bus_resp_valid, bus_read_data
    );

endinterface
`default_nettype wire

// File: rtl/lsu_lane_align.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lsu_lane_align : store lane shift/byte enables, load lane extract    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module lsu_lane_align
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  wire logic [3:0]                       store_size,
    input  wire logic [$clog2(DATA_WIDTH/8)-1:0]  store_offset,
    input  wire logic [DATA_WIDTH-1:0]            store_data,
    output logic      [DATA_WIDTH/8-1:0]          store_byte_enable,
    output logic      [DATA_WIDTH-1:0]            store_lane_data,
    input  wire logic [3:0]                       load_size,
    input  wire logic [$clog2(DATA_WIDTH/8)-1:0]  load_offset,
    input  wire logic                             load_unsigned,
    input  wire logic [DATA_WIDTH-1:0]            load_word,
    output logic      [DATA_WIDTH-1:0]            load_data
);
    localparam int BE_W = DATA_WIDTH / 8;

    logic [BE_W-1:0]       lane_mask;
    logic [DATA_WIDTH-1:0] load_shifted;

    always_comb begin
        case (store_size)
            4'd1:    lane_mask = BE_W'(1);
            4'd2:    lane_mask = BE_W'(3);
            4'd4:    lane_mask = BE_W'(4'hF);
            default: lane_mask = '1;
        endcase
    end

    assign store_byte_enable = lane_mask << store_offset;
    assign store_lane_data   = store_data << {store_offset, 3'b000};
    assign load_shifted      = load_word >> {load_offset, 3'b000};

    // Fill with the sign bit first, then overlay the selected lanes.
    always_comb begin
        load_data = load_shifted;
        case (load_size)
            4'd1: begin
                load_data      = {DATA_WIDTH{~load_unsigned & load_shifted[7]}};
                load_data[7:0] = load_shifted[7:0];
            end
            4'd2: begin
                load_data       = {DATA_WIDTH{~load_unsigned & load_shifted[15]}};
                load_data[15:0] = load_shifted[15:0];
            end
            4'd4: begin
                load_data       = {DATA_WIDTH{~load_unsigned & load_shifted[31]}};
                load_data[31:0] = load_shifted[31:0];
            end
            default: load_data = load_shifted;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | load_store_unit : multicycle load/store path to a wait-state bus.    |
// | Optional LSU_TIMEOUT_EN adds a response-wait timeout fault.          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input wire logic          clock,
    input wire logic          reset,
    load_store_unit_if.slave  lsu
);
    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int OFF_W = $clog2(BE_W);

    if (!(DATA_WIDTH == 32 || DATA_WIDTH == 64)) begin : g_bad_width
        $error("load_store_unit: DATA_WIDTH must be 32 or 64");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("load_store_unit: TIMEOUT_CYCLES must be at least 1");
    end

    lsu_state_t state, state_next;

    logic                  accept, bad_format, misaligned, fault_now, timed_out;
    logic [2:0]            req_format;
    logic [3:0]            req_size, req_offset;
    logic [BE_W-1:0]       store_be;
    logic [DATA_WIDTH-1:0] store_wd, load_data;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [BE_W-1:0]       be_q;
    logic [DATA_WIDTH-1:0] wdata_q, rdata_q;
    logic                  write_q, unsigned_q;
    logic [3:0]            size_q;
    logic [OFF_W-1:0]      offset_q;
    logic [1:0]            fault_q;

    // Stores have no extension, so bit 2 of the format is dropped for them.
    assign req_format = lsu.core_write ? {1'b0, lsu.core_format[1:0]} : lsu.core_format;
    assign req_size   = size_of_format(req_format, DATA_WIDTH == 64);
    assign req_offset = 4'(lsu.core_address[OFF_W-1:0]);
    assign bad_format = (req_size == 4'd0);
    assign misaligned = |(req_offset & (req_size - 4'd1));
    assign fault_now  = bad_format | misaligned;
    assign accept     = lsu.core_req_valid && (state == ST_IDLE);

    lsu_lane_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
        .store_size        (req_size),
        .store_offset      (lsu.core_address[OFF_W-1:0]),
        .store_data        (lsu.core_write_data),
        .store_byte_enable (store_be),
        .store_lane_data   (store_wd),
        .load_size         (size_q),
        .load_offset       (offset_q),
        .load_unsigned     (unsigned_q),
        .load_word         (lsu.bus_read_data),
        .load_data         (load_data)
    );

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)                wait_count <= '0;
        else if (state != ST_WAIT) wait_count <= '0;
        else                       wait_count <= wait_count + 1'b1;
    end

    assign timed_out = (state == ST_WAIT) && (wait_count == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timed_out = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (accept) state_next = fault_now ? ST_RESP : ST_REQ;
            ST_REQ:  if (lsu.bus_req_ready) state_next = ST_WAIT;
            ST_WAIT: if (lsu.bus_resp_valid || timed_out) state_next = ST_RESP;
            ST_RESP: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            addr_q     <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            write_q    <= 1'b0;
            unsigned_q <= 1'b0;
            size_q     <= '0;
            offset_q   <= '0;
            fault_q    <= FAULT_NONE;
        end else if (accept) begin
            addr_q     <= {lsu.core_address[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
            be_q       <= fault_now ? '0 : store_be;
            wdata_q    <= (lsu.core_write && !fault_now) ? store_wd : '0;
            rdata_q    <= '0;
            write_q    <= lsu.core_write;
            unsigned_q <= lsu.core_format[2];
            size_q     <= req_size;
            offset_q   <= lsu.core_address[OFF_W-1:0];
            fault_q    <= bad_format ? FAULT_FORMAT : (misaligned ? FAULT_MISALIGN : FAULT_NONE);
        end else if (state == ST_WAIT) begin
            if (lsu.bus_resp_valid) begin
                rdata_q <= write_q ? '0 : load_data;
            end else if (timed_out) begin
                rdata_q <= '0;
                fault_q <= FAULT_TIMEOUT;
            end
        end
    end

    assign lsu.core_req_ready   = (state == ST_IDLE);
    assign lsu.core_resp_valid  = (state == ST_RESP);
    assign lsu.core_read_data   = rdata_q;
    assign lsu.core_fault       = fault_q;
    assign lsu.bus_req_valid    = (state == ST_REQ);
    assign lsu.bus_address      = addr_q;
    assign lsu.bus_write_enable = write_q;
    assign lsu.bus_byte_enable  = be_q;
    assign lsu.bus_write_data   = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// Directed bench for load_store_unit: 32-bit and 64-bit instances driven from one vector table.
module tb_load_store_unit;
    import lsu_pkg::*;

    typedef struct {
        bit          w64;
        logic        wr;
        logic [2:0]  fmt;
        logic [31:0] addr;
        logic [63:0] wdata;
        logic [63:0] bus_rd;
        int          delay;
        logic [31:0] exp_addr;
        logic [7:0]  exp_be;
        logic [63:0] exp_wd;
        logic [63:0] exp_rd;
        logic [1:0]  exp_fault;
    } vec_t;

    logic        clk, rst_n;
    logic        sel64, req_valid, req_write, bus_ready, bus_rvalid;
    logic [2:0]  req_fmt;
    logic [31:0] req_addr;
    logic [63:0] req_wdata, bus_rdata;
    int          checks, errors;
    vec_t        vecs[$];

    load_store_unit_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) i32 ();
    load_store_unit_if #(.ADDR_WIDTH(32), .DATA_WIDTH(64)) i64 ();

    load_store_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(8)) dut32 (
        .clock(clk), .reset(rst_n), .lsu(i32));
    load_store_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .TIMEOUT_CYCLES(8)) dut64 (
        .clock(clk), .reset(rst_n), .lsu(i64));

    assign i32.core_req_valid  = req_valid & ~sel64;
    assign i32.core_write      = req_write;
    assign i32.core_format     = req_fmt;
    assign i32.core_address    = req_addr;
    assign i32.core_write_data = req_wdata[31:0];
    assign i32.bus_req_ready   = bus_ready & ~sel64;
    assign i32.bus_resp_valid  = bus_rvalid & ~sel64;
    assign i32.bus_read_data   = bus_rdata[31:0];
    assign i64.core_req_valid  = req_valid & sel64;
    assign i64.core_write      = req_write;
    assign i64.core_format     = req_fmt;
    assign i64.core_address    = req_addr;
    assign i64.core_write_data = req_wdata;
    assign i64.bus_req_ready   = bus_ready & sel64;
    assign i64.bus_resp_valid  = bus_rvalid & sel64;
    assign i64.bus_read_data   = bus_rdata;

    logic        o_ready, o_rvalid, o_breq, o_we;
    logic [1:0]  o_fault;
    logic [31:0] o_addr;
    logic [7:0]  o_be;
    logic [63:0] o_wd, o_rd;
    assign o_ready  = sel64 ? i64.core_req_ready   : i32.core_req_ready;
    assign o_rvalid = sel64 ? i64.core_resp_valid  : i32.core_resp_valid;
    assign o_breq   = sel64 ? i64.bus_req_valid    : i32.bus_req_valid;
    assign o_we     = sel64 ? i64.bus_write_enable : i32.bus_write_enable;
    assign o_fault  = sel64 ? i64.core_fault       : i32.core_fault;
    assign o_addr   = sel64 ? i64.bus_address      : i32.bus_address;
    assign o_be     = sel64 ? i64.bus_byte_enable  : {4'b0, i32.bus_byte_enable};
    assign o_wd     = sel64 ? i64.bus_write_data   : {32'b0, i32.bus_write_data};
    assign o_rd     = sel64 ? i64.core_read_data   : {32'b0, i32.core_read_data};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(bit w64, logic wr, logic [2:0] fmt, logic [31:0] addr,
                                logic [63:0] wd, logic [63:0] brd, int dly, logic [31:0] ea,
                                logic [7:0] ebe, logic [63:0] ewd, logic [63:0] erd, logic [1:0] ef);
        vec_t v;
        v.w64 = w64; v.wr = wr; v.fmt = fmt; v.addr = addr; v.wdata = wd; v.bus_rd = brd;
        v.delay = dly; v.exp_addr = ea; v.exp_be = ebe; v.exp_wd = ewd; v.exp_rd = erd;
        v.exp_fault = ef;
        return v;
    endfunction

    // One full transaction; bus responds the cycle after the request handshake.
    task automatic run(input vec_t v, input int idx);
        int lat, req_cycles, exp_lat;
        bit got, saw_req, hs_pending, hs_done;
        exp_lat = (v.exp_fault != FAULT_NONE) ? 1 : 3 + v.delay;
        @(negedge clk);
        sel64 = v.w64; bus_ready = 1'b0; bus_rvalid = 1'b0;
        #1;
        chk($sformatf("v%0d_req_ready", idx), o_ready, 1);
        req_valid = 1'b1; req_write = v.wr; req_fmt = v.fmt; req_addr = v.addr; req_wdata = v.wdata;
        @(posedge clk); lat = 1;
        @(negedge clk); req_valid = 1'b0;
        got = 0; saw_req = 0; hs_pending = 0; hs_done = 0; req_cycles = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            bus_rvalid = 1'b0;
            if (o_rvalid) begin
                got = 1;
            end else begin
                if (hs_done) begin
                    bus_rvalid = 1'b1; bus_rdata = v.bus_rd; hs_done = 0;
                end
                bus_ready = 1'b0;
                if (o_breq) begin
                    saw_req = 1;
                    chk($sformatf("v%0d_bus_addr", idx), o_addr, v.exp_addr);
                    chk($sformatf("v%0d_bus_be", idx), o_be, v.exp_be);
                    chk($sformatf("v%0d_bus_wd", idx), o_wd, v.exp_wd);
                    chk($sformatf("v%0d_bus_we", idx), o_we, v.wr);
                    if (req_cycles >= v.delay) begin
                        bus_ready = 1'b1; hs_pending = 1;
                    end
                    req_cycles++;
                end
                @(posedge clk); lat++;
                @(negedge clk);
                if (hs_pending) begin hs_done = 1; hs_pending = 0; end
            end
        end
        bus_ready = 1'b0;
        chk($sformatf("v%0d_resp_seen", idx), got, 1);
        chk($sformatf("v%0d_latency", idx), lat, exp_lat);
        chk($sformatf("v%0d_read_data", idx), o_rd, v.exp_rd);
        chk($sformatf("v%0d_fault", idx), o_fault, v.exp_fault);
        chk($sformatf("v%0d_bus_used", idx), saw_req, v.exp_fault == FAULT_NONE);
        chk($sformatf("v%0d_ready_in_resp", idx), o_ready, 0);
        @(posedge clk); @(negedge clk);
        chk($sformatf("v%0d_resp_one_cycle", idx), o_rvalid, 0);
    endtask

    initial begin
        int lat;
        checks = 0; errors = 0;
        sel64 = 0; req_valid = 0; req_write = 0; req_fmt = 0; req_addr = 0; req_wdata = 0;
        bus_ready = 0; bus_rvalid = 0; bus_rdata = 0;

        //          w64 wr fmt     addr          wdata                  bus_rd                 d  exp_addr      be     exp_wd                 exp_rd                 fault
        vecs.push_back(mk(0, 0, 3'b000, 32'h1003, 64'h0,                 64'h80FF_1234,          0, 32'h1000, 8'h08, 64'h0,                 64'hFFFF_FF80,          2'b00));
        vecs.push_back(mk(0, 1, 3'b001, 32'h2002, 64'h0000_ABCD,         64'hDEAD_BEEF,          4, 32'h2000, 8'h0C, 64'hABCD_0000,         64'h0,                  2'b00));
        vecs.push_back(mk(0, 0, 3'b010, 32'h0006, 64'h0,                 64'h0,                  0, 32'h0,    8'h00, 64'h0,                 64'h0,                  2'b01));
        vecs.push_back(mk(0, 0, 3'b111, 32'h0000, 64'h0,                 64'h0,                  0, 32'h0,    8'h00, 64'h0,                 64'h0,                  2'b10));
        vecs.push_back(mk(0, 0, 3'b100, 32'h1002, 64'h0,                 64'h80FF_1234,          0, 32'h1000, 8'h04, 64'h0,                 64'h0000_00FF,          2'b00));
        vecs.push_back(mk(0, 0, 3'b001, 32'h1002, 64'h0,                 64'h80FF_1234,          0, 32'h1000, 8'h0C, 64'h0,                 64'hFFFF_80FF,          2'b00));
        vecs.push_back(mk(0, 0, 3'b101, 32'h1002, 64'h0,                 64'h80FF_1234,          2, 32'h1000, 8'h0C, 64'h0,                 64'h0000_80FF,          2'b00));
        vecs.push_back(mk(0, 0, 3'b010, 32'h1004, 64'h0,                 64'h80FF_1234,          0, 32'h1004, 8'h0F, 64'h0,                 64'h80FF_1234,          2'b00));
        vecs.push_back(mk(0, 1, 3'b100, 32'h3001, 64'h0000_00AB,         64'h5555_5555,          1, 32'h3000, 8'h02, 64'h0000_AB00,         64'h0,                  2'b00));
        vecs.push_back(mk(0, 0, 3'b001, 32'h1001, 64'h0,                 64'h0,                  0, 32'h0,    8'h00, 64'h0,                 64'h0,                  2'b01));
        vecs.push_back(mk(0, 0, 3'b011, 32'h0000, 64'h0,                 64'h0,                  0, 32'h0,    8'h00, 64'h0,                 64'h0,                  2'b10));
        vecs.push_back(mk(0, 1, 3'b110, 32'h4000, 64'h1234_5678,         64'h0,                  0, 32'h4000, 8'h0F, 64'h1234_5678,         64'h0,                  2'b00));
        vecs.push_back(mk(0, 1, 3'b111, 32'h4000, 64'h1234_5678,         64'h0,                  0, 32'h0,    8'h00, 64'h0,                 64'h0,                  2'b10));
        vecs.push_back(mk(0, 0, 3'b110, 32'h4000, 64'h0,                 64'h0,                  0, 32'h0,    8'h00, 64'h0,                 64'h0,                  2'b10));
        vecs.push_back(mk(0, 0, 3'b000, 32'h0000, 64'h0,                 64'h0000_007F,          0, 32'h0,    8'h01, 64'h0,                 64'h0000_007F,          2'b00));
        vecs.push_back(mk(0, 1, 3'b000, 32'h5003, 64'h0000_00C3,         64'h0,                  0, 32'h5000, 8'h08, 64'hC300_0000,         64'h0,                  2'b00));
        vecs.push_back(mk(0, 1, 3'b010, 32'h5002, 64'h1111_1111,         64'h0,                  0, 32'h0,    8'h00, 64'h0,                 64'h0,                  2'b01));
        vecs.push_back(mk(1, 0, 3'b110, 32'h0004, 64'h0,                 64'hDEAD_BEEF_0000_0001, 0, 32'h0,    8'hF0, 64'h0,                 64'h0000_0000_DEAD_BEEF, 2'b00));
        vecs.push_back(mk(1, 0, 3'b010, 32'h0004, 64'h0,                 64'hDEAD_BEEF_0000_0001, 0, 32'h0,    8'hF0, 64'h0,                 64'hFFFF_FFFF_DEAD_BEEF, 2'b00));
        vecs.push_back(mk(1, 0, 3'b011, 32'h0008, 64'h0,                 64'h8000_0000_0000_0001, 1, 32'h8,    8'hFF, 64'h0,                 64'h8000_0000_0000_0001, 2'b00));
        vecs.push_back(mk(1, 0, 3'b011, 32'h0004, 64'h0,                 64'h0,                  0, 32'h0,    8'h00, 64'h0,                 64'h0,                  2'b01));
        vecs.push_back(mk(1, 1, 3'b111, 32'h0010, 64'h1122_3344_5566_7788, 64'h0,                0, 32'h10,   8'hFF, 64'h1122_3344_5566_7788, 64'h0,                2'b00));
        vecs.push_back(mk(1, 1, 3'b000, 32'h0007, 64'h0000_0000_0000_00AA, 64'h0,                0, 32'h0,    8'h80, 64'hAA00_0000_0000_0000, 64'h0,                2'b00));

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_ready32", i32.core_req_ready, 1);
        chk("reset_ready64", i64.core_req_ready, 1);
        chk("reset_resp32", i32.core_resp_valid, 0);
        chk("reset_breq32", i32.bus_req_valid, 0);
        chk("reset_fault32", i32.core_fault, 0);
        chk("reset_rdata64", i64.core_read_data, 0);
        chk("reset_be64", i64.bus_byte_enable, 0);
        rst_n = 1'b1;

        foreach (vecs[k]) run(vecs[k], k);

        // Reset while the bus response is outstanding.
        @(negedge clk);
        sel64 = 0; req_valid = 1; req_write = 0; req_fmt = 3'b010; req_addr = 32'h100; bus_ready = 1;
        @(posedge clk); @(negedge clk); req_valid = 0;
        @(posedge clk); @(negedge clk); bus_ready = 0;
        chk("wait_no_breq", i32.bus_req_valid, 0);
        chk("wait_not_ready", i32.core_req_ready, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_ready", i32.core_req_ready, 1);
        chk("async_rst_breq", i32.bus_req_valid, 0);
        chk("async_rst_addr", i32.bus_address, 0);
        chk("async_rst_be", i32.bus_byte_enable, 0);
        chk("async_rst_resp", i32.core_resp_valid, 0);
        @(negedge clk);
        rst_n = 1'b1; bus_rvalid = 1; bus_rdata = 64'h1234;
        @(posedge clk); @(negedge clk); bus_rvalid = 0;
        chk("stray_resp_ignored", i32.core_resp_valid, 0);
        chk("stray_ready", i32.core_req_ready, 1);
        run(vecs[0], 100);

`ifdef LSU_TIMEOUT_EN
        @(negedge clk);
        sel64 = 0; req_valid = 1; req_write = 0; req_fmt = 3'b010; req_addr = 32'h200;
        bus_ready = 1; bus_rvalid = 0; bus_rdata = 64'hFFFF_FFFF;
        @(posedge clk); lat = 1;
        @(negedge clk); req_valid = 0;
        for (int i = 0; i < 40 && !i32.core_resp_valid; i++) begin
            @(posedge clk); lat++;
            @(negedge clk);
        end
        bus_ready = 0;
        chk("timeout_seen", i32.core_resp_valid, 1);
        chk("timeout_latency", lat, 10);
        chk("timeout_fault", i32.core_fault, FAULT_TIMEOUT);
        chk("timeout_rdata", i32.core_read_data, 0);
        @(posedge clk); @(negedge clk);
        bus_rvalid = 1;
        @(posedge clk); @(negedge clk);
        bus_rvalid = 0;
        chk("late_resp_ignored", i32.core_resp_valid, 0);
        chk("late_resp_ready", i32.core_req_ready, 1);
        run(vecs[0], 101);
`else
        @(negedge clk);
        sel64 = 0; req_valid = 1; req_write = 0; req_fmt = 3'b010; req_addr = 32'h300;
        bus_ready = 1; bus_rvalid = 0;
        @(posedge clk); @(negedge clk); req_valid = 0;
        @(posedge clk); @(negedge clk); bus_ready = 0;
        repeat (30) @(posedge clk);
        @(negedge clk);
        chk("no_timeout_resp", i32.core_resp_valid, 0);
        chk("no_timeout_ready", i32.core_req_ready, 0);
        bus_rvalid = 1; bus_rdata = 64'hCAFE_F00D;
        @(posedge clk); @(negedge clk); bus_rvalid = 0;
        chk("late_resp_valid", i32.core_resp_valid, 1);
        chk("late_resp_data", i32.core_read_data, 32'hCAFE_F00D);
        chk("late_resp_fault", i32.core_fault, FAULT_NONE);
        @(posedge clk); @(negedge clk);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
